// File: rtl/cfu_rr_arbiter.sv
// Round-robin arbiter that shares one CFU among N_REQ requesters, with per-requester in-flight caps.
// Define CFU_ARB_RESP_REG_EN to add a one-entry response register on the return path.
module cfu_rr_arbiter #(
  parameter int N_REQ              = 4,
  parameter int CFU_INTERFACE_ID_W = 16,
  parameter int CFU_FUNCTION_ID_W  = 16,
  parameter int CFU_REORDER_ID_W   = 8,
  parameter int CFU_REQ_RESP_ID_W  = 6,
  parameter int CFU_REQ_INPUTS     = 2,
  parameter int CFU_REQ_DATA_W     = 32,
  parameter int CFU_RESP_OUTPUTS   = 1,
  parameter int CFU_RESP_DATA_W    = CFU_REQ_DATA_W,
  parameter int CFU_ERROR_ID_W     = CFU_RESP_DATA_W,
  parameter int MAX_OUTSTANDING    = 4,
  localparam int SEL_W             = $clog2(N_REQ),
  localparam int DID_W             = SEL_W + CFU_REQ_RESP_ID_W,
  localparam int RQ_W              = CFU_REQ_INPUTS * CFU_REQ_DATA_W,
  localparam int RS_W              = CFU_RESP_OUTPUTS * CFU_RESP_DATA_W
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   clock_en,
  input  logic [N_REQ-1:0]                       up_req_valid,
  output logic [N_REQ-1:0]                       up_req_ready,
  input  logic [N_REQ*CFU_INTERFACE_ID_W-1:0]    up_req_interface_id,
  input  logic [N_REQ*CFU_FUNCTION_ID_W-1:0]     up_req_function_id,
  input  logic [N_REQ*CFU_REORDER_ID_W-1:0]      up_req_reorder_id,
  input  logic [N_REQ*CFU_REQ_RESP_ID_W-1:0]     up_req_id,
  input  logic [N_REQ*RQ_W-1:0]                  up_req_data,
  output logic [N_REQ-1:0]                       up_resp_valid,
  input  logic [N_REQ-1:0]                       up_resp_ready,
  output logic [N_REQ*CFU_REQ_RESP_ID_W-1:0]     up_resp_id,
  output logic [N_REQ*RS_W-1:0]                  up_resp_data,
  output logic [N_REQ-1:0]                       up_resp_ok,
  output logic [N_REQ*CFU_ERROR_ID_W-1:0]        up_resp_error_id,
  output logic                                   cfu_req_valid,
  input  logic                                   cfu_req_ready,
  output logic [CFU_INTERFACE_ID_W-1:0]          cfu_req_interface_id,
  output logic [CFU_FUNCTION_ID_W-1:0]           cfu_req_function_id,
  output logic [CFU_REORDER_ID_W-1:0]            cfu_req_reorder_id,
  output logic [DID_W-1:0]                       cfu_req_id,
  output logic [RQ_W-1:0]                        cfu_req_data,
  input  logic                                   cfu_resp_valid,
  output logic                                   cfu_resp_ready,
  input  logic [DID_W-1:0]                       cfu_resp_id,
  input  logic [RS_W-1:0]                        cfu_resp_data,
  input  logic                                   cfu_resp_ok,
  input  logic [CFU_ERROR_ID_W-1:0]              cfu_resp_error_id,
  output logic                                   err_resp
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [SEL_W-1:0] LAST_G  = SEL_W'(N_REQ - 1);

  logic [SEL_W-1:0] r_rr_ptr;
  logic             r_lock;
  logic [SEL_W-1:0] r_locked_g;
  logic [CNT_W-1:0] r_out [N_REQ];
  logic             r_err;

  logic [N_REQ-1:0] w_elig;
  logic             w_found;
  logic [SEL_W-1:0] w_scan_g;
  logic [SEL_W-1:0] w_g;
  logic             w_any;
  logic [SEL_W-1:0] w_g_next;
  logic             w_req_hs;
  logic [N_REQ-1:0] w_inc;
  logic [N_REQ-1:0] w_dec;
  logic             w_dec_valid;
  logic [SEL_W-1:0] w_dec_dst;
  logic             w_err_set;

  logic [SEL_W-1:0]             w_dst;
  logic [CFU_REQ_RESP_ID_W-1:0] w_rid;
  logic                         w_dst_ok;
  logic [CNT_W-1:0]             w_dst_cnt;
  logic                         w_bad;
  logic                         w_cfu_resp_hs;

  // Eligibility: valid request and room under the in-flight cap
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_elig[i] = up_req_valid[i] && (r_out[i] < MAX_CNT);
    end
  end

  // Round-robin scan from the pointer; a stalled grant stays locked until accepted
  always_comb begin
    w_found  = 1'b0;
    w_scan_g = r_rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && w_elig[(int'(r_rr_ptr) + k) % N_REQ]) begin
        w_found  = 1'b1;
        w_scan_g = SEL_W'((int'(r_rr_ptr) + k) % N_REQ);
      end
    end
    if (r_lock) begin
      w_g   = r_locked_g;
      w_any = 1'b1;
    end else begin
      w_g   = w_scan_g;
      w_any = w_found;
    end
    if (w_g == LAST_G) begin
      w_g_next = '0;
    end else begin
      w_g_next = w_g + SEL_W'(1);
    end
  end

  assign cfu_req_valid        = clock_en && w_any;
  assign w_req_hs             = cfu_req_valid && cfu_req_ready;
  assign cfu_req_interface_id = up_req_interface_id[w_g*CFU_INTERFACE_ID_W +: CFU_INTERFACE_ID_W];
  assign cfu_req_function_id  = up_req_function_id[w_g*CFU_FUNCTION_ID_W +: CFU_FUNCTION_ID_W];
  assign cfu_req_reorder_id   = up_req_reorder_id[w_g*CFU_REORDER_ID_W +: CFU_REORDER_ID_W];
  assign cfu_req_id           = {w_g, up_req_id[w_g*CFU_REQ_RESP_ID_W +: CFU_REQ_RESP_ID_W]};
  assign cfu_req_data         = up_req_data[w_g*RQ_W +: RQ_W];

  // Upstream request ready: only the granted slot sees the downstream accept
  always_comb begin
    up_req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      up_req_ready[i] = w_req_hs && (w_g == SEL_W'(i));
    end
  end

  assign w_dst = cfu_resp_id[DID_W-1 -: SEL_W];
  assign w_rid = cfu_resp_id[CFU_REQ_RESP_ID_W-1:0];

  // Decode the response tag; out-of-range tags are caught without indexing past the array
  always_comb begin
    w_dst_ok  = 1'b0;
    w_dst_cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_dst == SEL_W'(i)) begin
        w_dst_ok  = 1'b1;
        w_dst_cnt = r_out[i];
      end
    end
  end

  assign w_bad         = !w_dst_ok || (w_dst_cnt == '0);
  assign w_cfu_resp_hs = clock_en && cfu_resp_valid && cfu_resp_ready;
  assign w_err_set     = w_cfu_resp_hs && w_bad;

`ifdef CFU_ARB_RESP_REG_EN
  logic                         r_full;
  logic [SEL_W-1:0]             r_rdst;
  logic [CFU_REQ_RESP_ID_W-1:0] r_rid;
  logic [RS_W-1:0]              r_rdata;
  logic                         r_rok;
  logic [CFU_ERROR_ID_W-1:0]    r_rerr;
  logic                         w_held_rdy;
  logic                         w_drain;

  // Upstream ready of whichever requester the held response belongs to
  always_comb begin
    w_held_rdy = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_rdst == SEL_W'(i)) begin
        w_held_rdy = up_resp_ready[i];
      end
    end
  end

  assign w_drain        = clock_en && r_full && w_held_rdy;
  assign cfu_resp_ready = clock_en && cfu_resp_valid && (!r_full || w_held_rdy);
  assign w_dec_valid    = w_drain;
  assign w_dec_dst      = r_rdst;

  // Response holding register: refills in the same cycle it drains
  always_ff @(posedge clock) begin
    if (reset) begin
      r_full  <= 1'b0;
      r_rdst  <= '0;
      r_rid   <= '0;
      r_rdata <= '0;
      r_rok   <= 1'b0;
      r_rerr  <= '0;
    end else if (w_cfu_resp_hs && !w_bad) begin
      r_full  <= 1'b1;
      r_rdst  <= w_dst;
      r_rid   <= w_rid;
      r_rdata <= cfu_resp_data;
      r_rok   <= cfu_resp_ok;
      r_rerr  <= cfu_resp_error_id;
    end else if (w_drain) begin
      r_full  <= 1'b0;
    end else begin
      r_full  <= r_full;
    end
  end

  // Upstream response fan-out from the register
  always_comb begin
    up_resp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      up_resp_valid[i] = clock_en && r_full && (r_rdst == SEL_W'(i));
      up_resp_id[i*CFU_REQ_RESP_ID_W +: CFU_REQ_RESP_ID_W] = r_rid;
      up_resp_data[i*RS_W +: RS_W]                         = r_rdata;
      up_resp_ok[i]                                        = r_rok;
      up_resp_error_id[i*CFU_ERROR_ID_W +: CFU_ERROR_ID_W] = r_rerr;
    end
  end
`else
  logic w_up_rdy_dst;

  // Upstream ready of the addressed requester
  always_comb begin
    w_up_rdy_dst = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_dst == SEL_W'(i)) begin
        w_up_rdy_dst = up_resp_ready[i];
      end
    end
  end

  // Unroutable responses are swallowed so the CFU never wedges on them
  assign cfu_resp_ready = clock_en && (w_bad ? cfu_resp_valid : w_up_rdy_dst);
  assign w_dec_valid    = w_cfu_resp_hs && !w_bad;
  assign w_dec_dst      = w_dst;

  // Combinational response fan-out; payload is broadcast, valid is steered
  always_comb begin
    up_resp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      up_resp_valid[i] = clock_en && cfu_resp_valid && !w_bad && (w_dst == SEL_W'(i));
      up_resp_id[i*CFU_REQ_RESP_ID_W +: CFU_REQ_RESP_ID_W] = w_rid;
      up_resp_data[i*RS_W +: RS_W]                         = cfu_resp_data;
      up_resp_ok[i]                                        = cfu_resp_ok;
      up_resp_error_id[i*CFU_ERROR_ID_W +: CFU_ERROR_ID_W] = cfu_resp_error_id;
    end
  end
`endif

  // Per-requester increment/decrement strobes
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_inc[i] = w_req_hs && (w_g == SEL_W'(i));
      w_dec[i] = w_dec_valid && (w_dec_dst == SEL_W'(i));
    end
  end

  // Outstanding counters; simultaneous issue and retire cancel out
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (reset) begin
        r_out[i] <= '0;
      end else if (w_inc[i] && !w_dec[i]) begin
        r_out[i] <= r_out[i] + CNT_W'(1);
      end else if (w_dec[i] && !w_inc[i]) begin
        r_out[i] <= r_out[i] - CNT_W'(1);
      end else begin
        r_out[i] <= r_out[i];
      end
    end
  end

  // Round-robin pointer and stall lock
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr   <= '0;
      r_lock     <= 1'b0;
      r_locked_g <= '0;
    end else if (w_req_hs) begin
      r_rr_ptr   <= w_g_next;
      r_lock     <= 1'b0;
    end else if (cfu_req_valid) begin
      r_lock     <= 1'b1;
      r_locked_g <= w_g;
    end else begin
      r_lock     <= r_lock;
    end
  end

  // Sticky flag for responses that could not be routed
  always_ff @(posedge clock) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign err_resp = r_err;

endmodule

// File: tb/tb_cfu_rr_arbiter.sv
// Self-checking bench for cfu_rr_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the arbitration rules.
module tb_cfu_rr_arbiter;
  localparam int N    = 4;
  localparam int MAXO = 2;

  logic clock = 1'b0;
  logic reset, clock_en;
  logic [N-1:0]    up_req_valid, up_req_ready, up_resp_valid, up_resp_ready, up_resp_ok;
  logic [N*16-1:0] up_req_interface_id, up_req_function_id;
  logic [N*8-1:0]  up_req_reorder_id;
  logic [N*6-1:0]  up_req_id, up_resp_id;
  logic [N*64-1:0] up_req_data;
  logic [N*32-1:0] up_resp_data, up_resp_error_id;
  logic        cfu_req_valid, cfu_req_ready, cfu_resp_valid, cfu_resp_ready, cfu_resp_ok, err_resp;
  logic [15:0] cfu_req_interface_id, cfu_req_function_id;
  logic [7:0]  cfu_req_reorder_id, cfu_req_id, cfu_resp_id;
  logic [63:0] cfu_req_data;
  logic [31:0] cfu_resp_data, cfu_resp_error_id;

  cfu_rr_arbiter #(.N_REQ(N), .MAX_OUTSTANDING(MAXO)) dut (
    .clock(clock), .reset(reset), .clock_en(clock_en),
    .up_req_valid(up_req_valid), .up_req_ready(up_req_ready),
    .up_req_interface_id(up_req_interface_id), .up_req_function_id(up_req_function_id),
    .up_req_reorder_id(up_req_reorder_id), .up_req_id(up_req_id), .up_req_data(up_req_data),
    .up_resp_valid(up_resp_valid), .up_resp_ready(up_resp_ready), .up_resp_id(up_resp_id),
    .up_resp_data(up_resp_data), .up_resp_ok(up_resp_ok), .up_resp_error_id(up_resp_error_id),
    .cfu_req_valid(cfu_req_valid), .cfu_req_ready(cfu_req_ready),
    .cfu_req_interface_id(cfu_req_interface_id), .cfu_req_function_id(cfu_req_function_id),
    .cfu_req_reorder_id(cfu_req_reorder_id), .cfu_req_id(cfu_req_id), .cfu_req_data(cfu_req_data),
    .cfu_resp_valid(cfu_resp_valid), .cfu_resp_ready(cfu_resp_ready), .cfu_resp_id(cfu_resp_id),
    .cfu_resp_data(cfu_resp_data), .cfu_resp_ok(cfu_resp_ok), .cfu_resp_error_id(cfu_resp_error_id),
    .err_resp(err_resp)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: in-flight count per requester, next-priority pointer, stall lock, sticky error
  int m_cnt [N];
  int m_ptr, m_lg;
  bit m_lock, m_err;

  logic [15:0] p_if   [N];
  logic [5:0]  p_id   [N];
  logic [63:0] p_data [N];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic renew(input int i);
    p_if[i]   = 16'($urandom);
    p_id[i]   = 6'($urandom);
    p_data[i] = {$urandom, $urandom};
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      up_req_interface_id[i*16 +: 16] = p_if[i];
      up_req_function_id[i*16 +: 16]  = ~p_if[i];
      up_req_reorder_id[i*8 +: 8]     = p_if[i][7:0];
      up_req_id[i*6 +: 6]             = p_id[i];
      up_req_data[i*64 +: 64]         = p_data[i];
    end
  endtask

  // Compare this cycle against the model, advance the model across the posedge, return at negedge
  task automatic step();
    int g, dst;
    bit any, cv, hs, bad, rv, crdy;
    logic [N-1:0] e_rdy, e_rv;
    #1;
    any = 1'b0;
    g   = m_ptr;
    if (m_lock) begin
      g   = m_lg;
      any = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!any && up_req_valid[(m_ptr + k) % N] && m_cnt[(m_ptr + k) % N] < MAXO) begin
          g   = (m_ptr + k) % N;
          any = 1'b1;
        end
      end
    end
    cv = clock_en && any;
    hs = cv && cfu_req_ready;
    e_rdy = '0;
    if (hs) e_rdy[g] = 1'b1;
    check_eq("req_valid", 64'(cfu_req_valid), 64'(cv));
    check_eq("up_req_ready", 64'(up_req_ready), 64'(e_rdy));
    if (cv) begin
      check_eq("req_id", 64'(cfu_req_id), 64'({2'(g), p_id[g]}));
      check_eq("req_if", 64'(cfu_req_interface_id), 64'(p_if[g]));
      check_eq("req_data", cfu_req_data, p_data[g]);
    end
    dst  = int'(cfu_resp_id[7:6]);
    bad  = (m_cnt[dst] == 0);
    rv   = clock_en && cfu_resp_valid && !bad;
    crdy = clock_en && (bad ? cfu_resp_valid : up_resp_ready[dst]);
    e_rv = '0;
    if (rv) e_rv[dst] = 1'b1;
    check_eq("up_resp_valid", 64'(up_resp_valid), 64'(e_rv));
    check_eq("cfu_resp_ready", 64'(cfu_resp_ready), 64'(crdy));
    if (rv) begin
      check_eq("up_resp_id", 64'(up_resp_id[dst*6 +: 6]), 64'(cfu_resp_id[5:0]));
      check_eq("up_resp_data", 64'(up_resp_data[dst*32 +: 32]), 64'(cfu_resp_data));
    end
    check_eq("err_resp", 64'(err_resp), 64'(m_err));
    if (clock_en) begin
      if (cfu_resp_valid && crdy && bad) m_err = 1'b1;
      if (hs) begin
        m_cnt[g]++;
        m_ptr  = (g + 1) % N;
        m_lock = 1'b0;
      end else if (cv) begin
        m_lock = 1'b1;
        m_lg   = g;
      end
      if (cfu_resp_valid && crdy && !bad) m_cnt[dst]--;
    end
    @(negedge clock);
    if (hs) begin
      renew(g);
      pack();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; clock_en = 1'b1;
    up_req_valid = '0; up_resp_ready = '0; cfu_req_ready = 1'b0;
    cfu_resp_valid = 1'b0; cfu_resp_id = '0; cfu_resp_data = '0;
    cfu_resp_ok = 1'b0; cfu_resp_error_id = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ptr = 0; m_lg = 0; m_lock = 1'b0; m_err = 1'b0;
    #1;
    check_eq("rst_req_valid", 64'(cfu_req_valid), 64'd0);
    check_eq("rst_up_req_ready", 64'(up_req_ready), 64'd0);
    check_eq("rst_up_resp_valid", 64'(up_resp_valid), 64'd0);
    check_eq("rst_cfu_resp_ready", 64'(cfu_resp_ready), 64'd0);
    check_eq("rst_err", 64'(err_resp), 64'd0);
  endtask

  initial begin
    logic [63:0] d0;
    for (int i = 0; i < N; i++) renew(i);
    pack();
    @(negedge clock);

    // Fair rotation with everyone requesting
    do_reset();
    up_req_valid = 4'hF; cfu_req_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 check_eq("t1_grant", 64'(cfu_req_id[7:6]), 64'(k % N));
      step();
    end

    // Stall locks the grant even when a higher-priority request appears
    do_reset();
    up_req_valid = 4'b0001; cfu_req_ready = 1'b1;
    step();
    cfu_req_ready = 1'b0;
    d0 = p_data[0];
    #1 check_eq("t2_grant_stall", 64'(cfu_req_id[7:6]), 64'd0);
    step();
    up_req_valid = 4'b0011;
    repeat (2) begin
      #1 check_eq("t2_grant_held", 64'(cfu_req_id[7:6]), 64'd0);
      check_eq("t2_data_held", cfu_req_data, d0);
      step();
    end
    cfu_req_ready = 1'b1;
    #1 check_eq("t2_accept0", 64'(up_req_ready), 64'b0001);
    step();
    up_req_valid = 4'b0010;
    #1 check_eq("t2_then1", 64'(cfu_req_id[7:6]), 64'd1);
    step();

    // Outstanding cap blocks, a response reopens it
    do_reset();
    up_req_valid = 4'b0100; cfu_req_ready = 1'b1;
    step(); step();
    #1 check_eq("t3_capped", 64'(up_req_ready), 64'd0);
    step();
    cfu_resp_valid = 1'b1; cfu_resp_id = {2'd2, 6'd9}; up_resp_ready = 4'b0100;
    #1 check_eq("t3_resp_routed", 64'(up_resp_valid), 64'b0100);
    step();
    cfu_resp_valid = 1'b0;
    #1 check_eq("t3_regrant", 64'(up_req_ready), 64'b0100);
    step();
    up_req_valid = '0;

    // Response backpressure, then delivery with id
    do_reset();
    up_req_valid = 4'b0010; cfu_req_ready = 1'b1;
    step();
    up_req_valid = '0;
    cfu_resp_valid = 1'b1; cfu_resp_id = {2'd1, 6'd5}; up_resp_ready = 4'b0000;
    #1 check_eq("t4_bp", 64'(cfu_resp_ready), 64'd0);
    step();
    up_resp_ready = 4'b0010;
    #1 check_eq("t4_ready", 64'(cfu_resp_ready), 64'd1);
    check_eq("t4_id", 64'(up_resp_id[11:6]), 64'd5);
    step();

    // Response to an idle requester is dropped and flagged
    cfu_resp_id = {2'd3, 6'd0}; up_resp_ready = 4'hF;
    #1 check_eq("t5_drop_ready", 64'(cfu_resp_ready), 64'd1);
    check_eq("t5_no_valid", 64'(up_resp_valid), 64'd0);
    step();
    cfu_resp_valid = 1'b0;
    repeat (3) begin
      #1 check_eq("t5_err_sticky", 64'(err_resp), 64'd1);
      step();
    end

    // Clock enable low freezes everything
    do_reset();
    up_req_valid = 4'hF; cfu_req_ready = 1'b1;
    step(); step();
    clock_en = 1'b0;
    repeat (3) begin
      #1 check_eq("t6_frozen", 64'(up_req_ready), 64'd0);
      step();
    end
    clock_en = 1'b1;
    #1 check_eq("t6_resume", 64'(cfu_req_id[7:6]), 64'd2);
    step();

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int d;
      clock_en = ($urandom % 8) != 0;
      for (int i = 0; i < N; i++)
        up_req_valid[i] = (m_lock && i == m_lg) ? 1'b1 : 1'($urandom % 2);
      cfu_req_ready     = ($urandom % 10) < 7;
      d                 = int'($urandom % N);
      cfu_resp_valid    = (m_cnt[d] != 0) && ($urandom % 2);
      cfu_resp_id       = {2'(d), 6'($urandom)};
      cfu_resp_data     = $urandom;
      cfu_resp_ok       = 1'($urandom);
      cfu_resp_error_id = $urandom;
      up_resp_ready     = 4'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
